timer_mc: RTL

Multi-channel, parametrised successor to the 32-bit peripheral timer. It provides one prescaled up-counter with a programmable TOP value, periodic or one-shot run modes, and NCMP independent compare channels. Each compare channel has a sticky flag, and an OR-reduced interrupt line is gated by per-flag enables. It sits behind the bus-slave register wrapper in the peripheral subsystem; the wrapper turns writes into the level controls and one-cycle pulses used below.

---
 rtl/timer_mc_pkg.sv | 11 +
 rtl/timer_mc_prescaler.sv | 19 +
 rtl/timer_mc.sv | 65 ++++++
 3 files changed

// File: rtl/timer_mc_pkg.sv
// timer_mc_pkg: shared state encoding and flag bit map for timer_mc.
package timer_mc_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int FLAG_OVF = 0;
  localparam int FLAG_CMP0 = 1;
  localparam int NCMP_MAX = 8;
  localparam int FLAGS_W_MAX = NCMP_MAX + 1;
  function automatic int flags_w(input int ncmp);
    return ncmp + 1;
  endfunction
endpackage

// File: rtl/timer_mc_prescaler.sv
// timer_mc_prescaler: divides clk into a tick every pre+1 cycles while run is high.
module timer_mc_prescaler #(
  parameter int PRE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PRE_WIDTH-1:0] pre,
  input  logic                 run,
  input  logic                 clear,
  output logic                 tick
);
  logic [PRE_WIDTH-1:0] prediv;
  // >= rather than == so lowering pre mid-run never strands prediv above it
  assign tick = run && (prediv >= pre);
  always_ff @(posedge clk or posedge rst)
    if (rst) prediv <= '0;
    else if (clear) prediv <= '0;
    else if (run) prediv <= tick ? '0 : prediv + 1'b1;
endmodule

// File: rtl/timer_mc.sv
// timer_mc: prescaled up-counter with TOP wrap, one-shot mode and NCMP sticky compare flags.
// Define TIMER_MC_PWM_EN to add the registered pwm outputs.
module timer_mc
  import timer_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PRE_WIDTH = 16,
  parameter int NCMP = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  oneshot,
  input  logic [PRE_WIDTH-1:0]  pre,
  input  logic [WIDTH-1:0]      top,
  input  logic [NCMP*WIDTH-1:0] cmp,
  input  logic [NCMP:0]         flag_clr,
  input  logic [NCMP:0]         irq_en,
  output logic [WIDTH-1:0]      cnt,
  output logic                  running,
  output logic [NCMP:0]         flags,
`ifdef TIMER_MC_PWM_EN
  output logic [NCMP-1:0]       pwm,
`endif
  output logic                  irq
);
  localparam int FW = flags_w(NCMP);
  state_t state;
  logic tick, wrap;
  logic [FW-1:0] ev;
  assign running = (state == RUN);
  assign wrap = (cnt == top);
  assign irq = |(flags & irq_en);
  timer_mc_prescaler #(.PRE_WIDTH(PRE_WIDTH)) u_pre (
    .clk(clk), .rst(rst), .pre(pre), .run(running && !stop),
    .clear(start && !stop), .tick(tick)
  );
  always_comb begin
    ev = '0;
    ev[FLAG_OVF] = tick && wrap;
    for (int i = 0; i < NCMP; i++) ev[FLAG_CMP0+i] = tick && (cnt == cmp[i*WIDTH +: WIDTH]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      flags <= '0;
    end else begin
      flags <= (flags & ~flag_clr) | ev;
      if (stop) state <= IDLE;
      else if (start) begin
        state <= RUN;
        cnt <= '0;
      end else if (tick) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
        if (wrap && oneshot) state <= IDLE;
      end
    end
`ifdef TIMER_MC_PWM_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) pwm <= '0;
    else for (int i = 0; i < NCMP; i++) pwm[i] <= running && (cnt < cmp[i*WIDTH +: WIDTH]);
`endif
endmodule
